sm83_pc_seq: RTL and testbench

Sequencer for the SM83 program-counter datapath. It holds the 16-bit PC and decides when the PC drives the address bus. It also applies the PC update for each command type: increment, absolute load, relative jump, RST vector and interrupt vector. It sits between the decoder/control cells and the PC output drivers, and shares the address bus with other address sources (SP, HL, etc.) through a request/grant handshake with the external bus arbiter.

---
 rtl/sm83_pc_seq.sv | 183 ++++++++++++++++++
 tb/tb_sm83_pc_seq.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sm83_pc_seq.sv
// SM83 program-counter sequencer: holds PC, arbitrates for the address bus on
// opcode fetch, and applies increment / load / relative / RST / IRQ updates.
module sm83_pc_seq #(
  parameter logic [15:0] RESET_PC   = 16'h0000,
  parameter logic [15:0] IRQ_BASE   = 16'h0040,
  parameter int          IRQ_STRIDE = 8
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [15:0] cmd_data,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic        addr_oe,
  output logic [15:0] addr_out,
  output logic [15:0] pc,
  output logic        irq_ack,
  output logic [2:0]  irq_idx,
  output logic        busy
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_REQ   = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;
  localparam logic [1:0] ST_UPD   = 2'd3;

  localparam logic [2:0] OP_FETCH = 3'd0;
  localparam logic [2:0] OP_LOAD  = 3'd1;
  localparam logic [2:0] OP_REL   = 3'd2;
  localparam logic [2:0] OP_RST   = 3'd3;
  localparam logic [2:0] OP_IRQ   = 3'd4;

  localparam logic [15:0] STRIDE_W = 16'(IRQ_STRIDE);

  function automatic logic [15:0] sext8(input logic [7:0] v);
    return {{8{v[7]}}, v};
  endfunction

  // Lowest set bit has the highest interrupt priority.
  function automatic logic [2:0] lowest_set(input logic [4:0] mask);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 4; i >= 0; i--) begin
      if (mask[i]) begin
        idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [15:0] irq_vector(input logic [2:0] idx);
    return IRQ_BASE + ({13'd0, idx} * STRIDE_W);
  endfunction

  logic [1:0]  state_r;
  logic [15:0] pc_r;
  logic [2:0]  op_r;
  logic [15:0] data_r;
  logic        cmd_ready_r;
  logic        bus_req_r;
  logic        addr_oe_r;
  logic [15:0] addr_out_r;
  logic        irq_ack_r;
  logic [2:0]  irq_idx_r;
  logic        busy_r;

  logic [1:0]  state_nxt_s;
  logic [15:0] pc_nxt_s;
  logic        accept_s;
  logic        irq_hit_s;
  logic [2:0]  irq_new_idx_s;

  assign accept_s      = cmd_valid & cmd_ready_r;
  assign irq_new_idx_s = lowest_set(cmd_data[4:0]);
  assign irq_hit_s     = accept_s & (cmd_op == OP_IRQ) & (|cmd_data[4:0]);

  // Next-state decode for the sequencer FSM.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = (cmd_op == OP_FETCH) ? ST_REQ : ST_UPD;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_REQ: begin
        if (bus_gnt) begin
          state_nxt_s = ST_DRIVE;
        end else begin
          state_nxt_s = ST_REQ;
        end
      end
      ST_DRIVE: state_nxt_s = ST_IDLE;
      ST_UPD:   state_nxt_s = ST_IDLE;
      default:  state_nxt_s = ST_IDLE;
    endcase
  end

  // PC update applied at the edge leaving DRIVE or UPD; captured operands only.
  always_comb begin
    pc_nxt_s = pc_r;
    case (state_r)
      ST_DRIVE: begin
        if (data_r[0]) begin
          pc_nxt_s = pc_r;
        end else begin
          pc_nxt_s = pc_r + 16'd1;
        end
      end
      ST_UPD: begin
        case (op_r)
          OP_LOAD: pc_nxt_s = data_r;
          OP_REL:  pc_nxt_s = pc_r + sext8(data_r[7:0]);
          OP_RST:  pc_nxt_s = {10'd0, data_r[2:0], 3'b000};
          OP_IRQ: begin
            if (|data_r[4:0]) begin
              pc_nxt_s = irq_vector(lowest_set(data_r[4:0]));
            end else begin
              pc_nxt_s = pc_r;
            end
          end
          default: pc_nxt_s = pc_r;
        endcase
      end
      default: pc_nxt_s = pc_r;
    endcase
  end

  // State, PC and command capture registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_r <= ST_IDLE;
      pc_r    <= RESET_PC;
      op_r    <= 3'd0;
      data_r  <= 16'd0;
    end else begin
      state_r <= state_nxt_s;
      pc_r    <= pc_nxt_s;
      if (accept_s) begin
        op_r   <= cmd_op;
        data_r <= cmd_data;
      end else begin
        op_r   <= op_r;
        data_r <= data_r;
      end
    end
  end

  // Outputs registered from the next state so they line up with state_r.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      cmd_ready_r <= 1'b1;
      busy_r      <= 1'b0;
      bus_req_r   <= 1'b0;
      addr_oe_r   <= 1'b0;
      addr_out_r  <= 16'd0;
      irq_ack_r   <= 1'b0;
      irq_idx_r   <= 3'd0;
    end else begin
      cmd_ready_r <= (state_nxt_s == ST_IDLE);
      busy_r      <= (state_nxt_s != ST_IDLE);
      bus_req_r   <= (state_nxt_s == ST_REQ) || (state_nxt_s == ST_DRIVE);
      addr_oe_r   <= (state_nxt_s == ST_DRIVE);
      addr_out_r  <= (state_nxt_s == ST_DRIVE) ? pc_nxt_s : 16'd0;
      irq_ack_r   <= irq_hit_s;
      irq_idx_r   <= irq_hit_s ? irq_new_idx_s : 3'd0;
    end
  end

  assign cmd_ready = cmd_ready_r;
  assign busy      = busy_r;
  assign bus_req   = bus_req_r;
  assign addr_oe   = addr_oe_r;
  assign addr_out  = addr_out_r;
  assign pc        = pc_r;
  assign irq_ack   = irq_ack_r;
  assign irq_idx   = irq_idx_r;

endmodule

// File: tb/tb_sm83_pc_seq.sv
// Directed bench for sm83_pc_seq: transaction-level model checked every cycle,
// plus literal expectations from hand-worked scenarios.
module tb_sm83_pc_seq;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = 3'd0;
  logic [15:0] cmd_data = 16'd0;
  logic        bus_gnt = 1'b0;
  logic        cmd_ready, bus_req, addr_oe, irq_ack, busy;
  logic [15:0] addr_out, pc;
  logic [2:0]  irq_idx;

  int checks = 0;
  int errors = 0;

  sm83_pc_seq dut (
    .clk(clk), .nreset(nreset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .bus_req(bus_req), .bus_gnt(bus_gnt),
    .addr_oe(addr_oe), .addr_out(addr_out), .pc(pc), .irq_ack(irq_ack),
    .irq_idx(irq_idx), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic        m_ready, m_wait, m_drive, m_upd;
  logic [15:0] m_pc;
  logic [2:0]  m_op;
  logic [15:0] m_data;

  function automatic logic [15:0] model_target(input logic [2:0] op, input logic [15:0] d,
                                               input logic [15:0] cur);
    int off;
    case (op)
      3'd1: return d;
      3'd2: begin
        off = int'(d[7:0]);
        if (d[7]) off = off - 256;
        return 16'(int'(cur) + off);
      end
      3'd3: return 16'(int'(d[2:0]) * 8);
      3'd4: begin
        for (int i = 0; i < 5; i++) if (d[i]) return 16'(64 + i * 8);
        return cur;
      end
      default: return cur;
    endcase
  endfunction

  function automatic logic [2:0] model_idx(input logic [4:0] mask);
    for (int i = 0; i < 5; i++) if (mask[i]) return 3'(i);
    return 3'd0;
  endfunction

  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      m_ready <= 1'b1; m_wait <= 1'b0; m_drive <= 1'b0; m_upd <= 1'b0;
      m_pc <= 16'h0000; m_op <= 3'd0; m_data <= 16'd0;
    end else if (m_ready && cmd_valid) begin
      m_ready <= 1'b0; m_op <= cmd_op; m_data <= cmd_data;
      if (cmd_op == 3'd0) m_wait <= 1'b1;
      else m_upd <= 1'b1;
    end else if (m_wait) begin
      if (bus_gnt) begin m_wait <= 1'b0; m_drive <= 1'b1; end
    end else if (m_drive) begin
      m_drive <= 1'b0; m_ready <= 1'b1;
      if (!m_data[0]) m_pc <= m_pc + 16'd1;
    end else if (m_upd) begin
      m_upd <= 1'b0; m_ready <= 1'b1;
      m_pc <= model_target(m_op, m_data, m_pc);
    end
  end

  // ---------------- compare + event counters ----------------
  int n_acc = 0, n_breq = 0, n_oe = 0, n_ack = 0;
  logic [15:0] last_addr = 16'd0;
  logic [2:0]  last_idx = 3'd0;
  logic [15:0] prev_pc = 16'd0;
  logic [15:0] pc_q[$];

  always @(posedge clk) begin
    logic acc_now;
    logic exp_ack;
    acc_now = cmd_valid && cmd_ready;
    #1;
    if (nreset) begin
      exp_ack = m_upd && (m_op == 3'd4) && (m_data[4:0] != 5'd0);
      check16("cmd_ready", {15'd0, cmd_ready}, {15'd0, m_ready});
      check16("busy", {15'd0, busy}, {15'd0, !m_ready});
      check16("bus_req", {15'd0, bus_req}, {15'd0, m_wait | m_drive});
      check16("addr_oe", {15'd0, addr_oe}, {15'd0, m_drive});
      check16("addr_out", addr_out, m_drive ? m_pc : 16'h0000);
      check16("pc", pc, m_pc);
      check16("irq_ack", {15'd0, irq_ack}, {15'd0, exp_ack});
      if (exp_ack) check16("irq_idx", {13'd0, irq_idx}, {13'd0, model_idx(m_data[4:0])});
      if (acc_now) n_acc++;
      if (bus_req) n_breq++;
      if (addr_oe) begin n_oe++; last_addr = addr_out; end
      if (irq_ack) begin n_ack++; last_idx = irq_idx; end
      if (pc !== prev_pc) begin pc_q.push_back(pc); prev_pc = pc; end
    end else begin
      prev_pc = pc;
    end
  end

  // ---------------- stimulus helpers (called at negedge) ----------------
  task automatic wait_idle();
    int t = 0;
    while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL wait_idle: cmd_ready still %b after %0d cycles", cmd_ready, t);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [15:0] d);
    wait_idle();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic fetch(input logic [15:0] d, input int gnt_delay);
    bus_gnt = 1'b0;
    issue(3'd0, d);
    repeat (gnt_delay - 1) @(negedge clk);
    bus_gnt = 1'b1;
    @(negedge clk);
    bus_gnt = 1'b0;
    wait_idle();
  endtask

  task automatic clear_counts();
    n_acc = 0; n_breq = 0; n_oe = 0; n_ack = 0;
  endtask

  logic [2:0]  b2b_ops[3]  = '{3'd0, 3'd0, 3'd1};
  logic [15:0] b2b_data[3] = '{16'h0000, 16'h0000, 16'hBEEF};

  initial begin
    int k;
    int t;
    repeat (3) @(negedge clk);
    check16("rst_pc", pc, 16'h0000);
    check16("rst_ready", {15'd0, cmd_ready}, 16'd1);
    check16("rst_busreq", {15'd0, bus_req}, 16'd0);
    nreset = 1'b1;
    @(negedge clk);

    // Reset asserted while driving the bus
    issue(3'd1, 16'h1234);
    wait_idle();
    bus_gnt = 1'b1;
    issue(3'd0, 16'h0000);
    @(negedge clk);
    check16("pre_rst_oe", {15'd0, addr_oe}, 16'd1);
    check16("pre_rst_addr", addr_out, 16'h1234);
    nreset = 1'b0;
    #1;
    check16("midrst_pc", pc, 16'h0000);
    check16("midrst_oe", {15'd0, addr_oe}, 16'd0);
    check16("midrst_busreq", {15'd0, bus_req}, 16'd0);
    bus_gnt = 1'b0;
    @(negedge clk);
    nreset = 1'b1;
    @(negedge clk);
    check16("postrst_ready", {15'd0, cmd_ready}, 16'd1);

    // Fetch with grant on the third request cycle
    issue(3'd1, 16'h0100);
    wait_idle();
    clear_counts();
    fetch(16'h0000, 3);
    check16("fetch_breq_cycles", 16'(n_breq), 16'd4);
    check16("fetch_oe_cycles", 16'(n_oe), 16'd1);
    check16("fetch_addr", last_addr, 16'h0100);
    check16("fetch_pc", pc, 16'h0101);

    // HALT-bug fetch leaves PC alone
    issue(3'd1, 16'h0100);
    wait_idle();
    fetch(16'h0001, 2);
    check16("noinc_addr", last_addr, 16'h0100);
    check16("noinc_pc", pc, 16'h0100);

    // Wrap cases
    issue(3'd1, 16'hFFFF);
    wait_idle();
    fetch(16'h0000, 1);
    check16("wrap_addr", last_addr, 16'hFFFF);
    check16("wrap_pc", pc, 16'h0000);
    issue(3'd1, 16'h0005);
    issue(3'd2, 16'h0080);
    wait_idle();
    check16("rel_neg", pc, 16'hFF85);
    issue(3'd1, 16'hFFF0);
    issue(3'd2, 16'h0020);
    wait_idle();
    check16("rel_wrap", pc, 16'h0010);

    // LOAD timing and no bus use
    clear_counts();
    issue(3'd1, 16'hC3A5);
    check16("load_pc_in_upd", pc, 16'h0010);
    @(negedge clk);
    check16("load_pc", pc, 16'hC3A5);
    check16("load_breq", 16'(n_breq), 16'd0);

    issue(3'd3, 16'h0007);
    wait_idle();
    check16("rst_vec", pc, 16'h0038);

    // Interrupts
    clear_counts();
    issue(3'd4, 16'h0014);
    wait_idle();
    check16("irq_pc", pc, 16'h0050);
    check16("irq_ack_count", 16'(n_ack), 16'd1);
    check16("irq_idx_lit", {13'd0, last_idx}, 16'd2);
    clear_counts();
    issue(3'd4, 16'h0000);
    wait_idle();
    check16("irq0_pc", pc, 16'h0050);
    check16("irq0_ack_count", 16'(n_ack), 16'd0);

    // Reserved op is a NOP
    issue(3'd6, 16'hFFFF);
    wait_idle();
    check16("nop_pc", pc, 16'h0050);

    // Back-to-back with cmd_valid held
    issue(3'd1, 16'h0000);
    wait_idle();
    pc_q.delete();
    clear_counts();
    bus_gnt = 1'b1;
    cmd_valid = 1'b1; cmd_op = b2b_ops[0]; cmd_data = b2b_data[0];
    k = 0; t = 0;
    while (k < 3 && t < 200) begin
      @(negedge clk);
      t++;
      k = n_acc;
      if (k < 3) begin cmd_op = b2b_ops[k]; cmd_data = b2b_data[k]; end
      else cmd_valid = 1'b0;
    end
    cmd_valid = 1'b0;
    wait_idle();
    repeat (3) @(negedge clk);
    bus_gnt = 1'b0;
    check16("b2b_accepts", 16'(n_acc), 16'd3);
    check16("b2b_pc_changes", 16'(pc_q.size()), 16'd3);
    if (pc_q.size() == 3) begin
      check16("b2b_pc0", pc_q[0], 16'h0001);
      check16("b2b_pc1", pc_q[1], 16'h0002);
      check16("b2b_pc2", pc_q[2], 16'hBEEF);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
